mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_FIRST, 1, when both masters request with no prior contention history, the data master wins (0: instruction master wins).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 instr_m_addr  in  19  instruction master word address [19:1].
REQ-006 instr_m_access  in  1  instruction master request, held until its ack.
REQ-007 instr_m_ack  out  1  instruction master acknowledge.
REQ-008 instr_m_data_in  out  16  read data to instruction master.
REQ-009 data_m_addr  in  19  data (load/store) master word address [19:1].
REQ-010 data_m_data_out  in  16  data master write data.
REQ-011 data_m_access  in  1  data master request, held until its ack.
REQ-012 data_m_wr_en  in  1  data master write enable.
REQ-013 data_m_bytesel  in  2  data master byte lanes.
REQ-014 data_m_ack  out  1  data master acknowledge.
REQ-015 data_m_data_in  out  16  read data to data master.
REQ-016 q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel  out  19/16/1/1/2  shared memory bus request.
REQ-017 q_m_data_in  in  16  memory read data; q_m_ack  in  1  memory acknowledge.
REQ-018 busy  out  1  high whenever a grant is held.

Function
REQ-019 State SHALL be one of IDLE, GRANT_INSTR, GRANT_DATA, plus a 1-bit last_was_data flag.
REQ-020 In IDLE, if exactly one master has access high, the next state SHALL be that master's grant.
REQ-021 In IDLE with both requesting: if last_was_data is set, grant instruction, else grant data; after reset, last_was_data = ~DATA_FIRST.
REQ-022 last_was_data SHALL update only on entry to a grant state (1 for data, 0 for instruction).
REQ-023 Grant latency SHALL be exactly one cycle: a request sampled in IDLE at edge N drives the bus from cycle N+1.
REQ-024 In a grant state, q_m_access SHALL equal the granted master's access AND NOT q_m_ack (combinational).
REQ-025 q_m_addr SHALL be the granted master's address; q_m_data_out, q_m_wr_en, q_m_bytesel SHALL be the data master's values in GRANT_DATA.
REQ-026 In GRANT_INSTR, q_m_wr_en = 0, q_m_bytesel = 2'b11, q_m_data_out = 0; in IDLE all q_m_* outputs SHALL be 0.
REQ-027 q_m_ack SHALL be forwarded combinationally only to the granted master; the other master's ack SHALL be 0.
REQ-028 q_m_data_in SHALL be broadcast unregistered to both data_in outputs.
REQ-029 On q_m_ack in a grant state, the next state SHALL be IDLE; one IDLE cycle always separates consecutive grants.
REQ-030 If the granted master drops access without an ack, the next state SHALL be IDLE and no ack SHALL be produced.
REQ-031 q_m_ack while in IDLE SHALL be ignored: no master ack, no state change.
REQ-032 A data master back-to-back (e.g. unaligned second byte) re-request SHALL compete normally in the following IDLE cycle; the instruction master SHALL win it if pending.
REQ-033 busy SHALL equal (state != IDLE).

Reset
REQ-034 On reset: state IDLE, last_was_data = ~DATA_FIRST, all q_m_* outputs, both acks and busy 0 in the following cycle.
REQ-035 Reset asserted mid-grant SHALL abandon the transfer; an ack arriving in the same cycle as reset SHALL NOT reach a master after the reset edge.

Verification
REQ-036 Data only: data_m_access=1, addr 19'h01234, wr_en=1, bytesel 2'b10 -> next cycle q_m_addr=19'h01234, q_m_wr_en=1, q_m_bytesel=2'b10; q_m_ack -> data_m_ack=1 same cycle, IDLE next.
REQ-037 Contention after reset (DATA_FIRST=1): both request in same cycle -> GRANT_DATA first, then after ack plus one IDLE cycle, GRANT_INSTR.
REQ-038 Fairness: data re-requests immediately after its ack while instr pending -> instruction granted next; data waits until instruction ack.
REQ-039 Instruction read: q_m_data_in=16'hBEEF with q_m_ack in GRANT_INSTR -> instr_m_ack=1, instr_m_data_in=16'hBEEF, data_m_ack=0.
REQ-040 Abort: granted master drops access without ack -> IDLE next cycle, no acks; stray q_m_ack in IDLE -> no acks.
REQ-041 Reset mid-grant with q_m_ack high -> following cycle IDLE, all outputs 0, then fresh arbitration per REQ-021.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction and data masters share one memory bus.
// Contention alternates via last_was_data; one IDLE cycle always separates grants.
module mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_was_data, last_was_data_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_was_data <= ~DATA_FIRST;
    end else begin
      state         <= state_nxt;
      last_was_data <= last_was_data_nxt;
    end
  end

  // Handshake: a master holds access until its ack; an ack completes the
  // transfer in the cycle it is seen, and the arbiter returns to IDLE next.
  always_comb begin
    state_nxt         = state;
    last_was_data_nxt = last_was_data;
    case (state)
      IDLE: begin
        if (instr_m_access && data_m_access) begin
          if (last_was_data) begin
            state_nxt         = GRANT_INSTR;
            last_was_data_nxt = 1'b0;
          end else begin
            state_nxt         = GRANT_DATA;
            last_was_data_nxt = 1'b1;
          end
        end else if (data_m_access) begin
          state_nxt         = GRANT_DATA;
          last_was_data_nxt = 1'b1;
        end else if (instr_m_access) begin
          state_nxt         = GRANT_INSTR;
          last_was_data_nxt = 1'b0;
        end
      end
      GRANT_INSTR: begin
        if (q_m_ack || !instr_m_access) state_nxt = IDLE;
      end
      GRANT_DATA: begin
        if (q_m_ack || !data_m_access) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (state)
      GRANT_INSTR: begin
        q_m_addr    = instr_m_addr;
        q_m_access  = instr_m_access & ~q_m_ack;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack;
      end
      GRANT_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access & ~q_m_ack;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
      end
      default: ;
    endcase
  end

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-master transfers, contention,
// fairness, abort, stray acks and reset mid-grant.
module tb_mem_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GI   = 2'd1;
  localparam logic [1:0] S_GD   = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic [15:0] q_m_data_in;
  logic        q_m_ack;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack),
    .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_qacc"}, 32'(q_m_access), 32'd0);
    check({tag, "_qaddr"}, 32'(q_m_addr), 32'd0);
    check({tag, "_qwr"}, 32'(q_m_wr_en), 32'd0);
    check({tag, "_qbs"}, 32'(q_m_bytesel), 32'd0);
    check({tag, "_qdo"}, 32'(q_m_data_out), 32'd0);
    check({tag, "_iack"}, 32'(instr_m_ack), 32'd0);
    check({tag, "_dack"}, 32'(data_m_ack), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    instr_m_addr = '0; instr_m_access = 1'b0;
    data_m_addr = '0; data_m_data_out = '0; data_m_access = 1'b0;
    data_m_wr_en = 1'b0; data_m_bytesel = 2'b00;
    q_m_data_in = '0; q_m_ack = 1'b0;

    // Reset state
    step(); step();
    reset = 1'b0;
    settle();
    check_idle("reset");

    // Data-only write
    data_m_addr = 19'h01234; data_m_wr_en = 1'b1; data_m_bytesel = 2'b10;
    data_m_data_out = 16'h5A5A; data_m_access = 1'b1;
    settle();
    check("d_latency_qacc", 32'(q_m_access), 32'd0);
    step();
    check("d_state", 32'(state_dbg), 32'(S_GD));
    check("d_busy", 32'(busy), 32'd1);
    check("d_qaddr", 32'(q_m_addr), 32'h01234);
    check("d_qwr", 32'(q_m_wr_en), 32'd1);
    check("d_qbs", 32'(q_m_bytesel), 32'(2'b10));
    check("d_qdo", 32'(q_m_data_out), 32'h5A5A);
    check("d_qacc", 32'(q_m_access), 32'd1);
    q_m_ack = 1'b1; q_m_data_in = 16'h1234;
    settle();
    check("d_dack", 32'(data_m_ack), 32'd1);
    check("d_iack", 32'(instr_m_ack), 32'd0);
    check("d_qacc_on_ack", 32'(q_m_access), 32'd0);
    check("d_rdata", 32'(data_m_data_in), 32'h1234);
    step();
    data_m_access = 1'b0; q_m_ack = 1'b0;
    settle();
    check_idle("d_done");

    // Contention right after reset: data wins first
    reset = 1'b1;
    step();
    reset = 1'b0;
    instr_m_addr = 19'h00100; instr_m_access = 1'b1;
    data_m_addr = 19'h00200; data_m_wr_en = 1'b0; data_m_bytesel = 2'b11;
    data_m_data_out = 16'h7777; data_m_access = 1'b1;
    step();
    check("c_state1", 32'(state_dbg), 32'(S_GD));
    check("c_qaddr1", 32'(q_m_addr), 32'h00200);
    q_m_ack = 1'b1;
    settle();
    check("c_dack1", 32'(data_m_ack), 32'd1);
    check("c_iack1", 32'(instr_m_ack), 32'd0);
    step();
    data_m_access = 1'b0; q_m_ack = 1'b0;
    settle();
    check("c_gap_state", 32'(state_dbg), 32'(S_IDLE));
    check("c_gap_qacc", 32'(q_m_access), 32'd0);
    step();
    check("c_state2", 32'(state_dbg), 32'(S_GI));
    check("c_qaddr2", 32'(q_m_addr), 32'h00100);
    check("c_qwr2", 32'(q_m_wr_en), 32'd0);
    check("c_qbs2", 32'(q_m_bytesel), 32'(2'b11));
    check("c_qdo2", 32'(q_m_data_out), 32'd0);
    check("c_qacc2", 32'(q_m_access), 32'd1);

    // Instruction read returns BEEF
    q_m_ack = 1'b1; q_m_data_in = 16'hBEEF;
    settle();
    check("i_iack", 32'(instr_m_ack), 32'd1);
    check("i_rdata", 32'(instr_m_data_in), 32'hBEEF);
    check("i_dack", 32'(data_m_ack), 32'd0);
    step();
    instr_m_access = 1'b0; q_m_ack = 1'b0;
    settle();
    check_idle("i_done");

    // Fairness: data re-requests right after its ack while instr pending
    data_m_addr = 19'h00300; data_m_access = 1'b1;
    step();
    check("f_state1", 32'(state_dbg), 32'(S_GD));
    instr_m_addr = 19'h00400; instr_m_access = 1'b1;
    q_m_ack = 1'b1;
    settle();
    check("f_dack1", 32'(data_m_ack), 32'd1);
    step();
    data_m_addr = 19'h00301; q_m_ack = 1'b0;
    settle();
    check("f_gap_state", 32'(state_dbg), 32'(S_IDLE));
    step();
    check("f_state2", 32'(state_dbg), 32'(S_GI));
    check("f_qaddr2", 32'(q_m_addr), 32'h00400);
    step();
    check("f_hold_state", 32'(state_dbg), 32'(S_GI));
    q_m_ack = 1'b1;
    settle();
    check("f_iack2", 32'(instr_m_ack), 32'd1);
    check("f_dack2", 32'(data_m_ack), 32'd0);
    step();
    instr_m_access = 1'b0; q_m_ack = 1'b0;
    settle();
    check("f_gap2_state", 32'(state_dbg), 32'(S_IDLE));
    step();
    check("f_state3", 32'(state_dbg), 32'(S_GD));
    check("f_qaddr3", 32'(q_m_addr), 32'h00301);
    q_m_ack = 1'b1;
    settle();
    check("f_dack3", 32'(data_m_ack), 32'd1);
    step();
    data_m_access = 1'b0; q_m_ack = 1'b0;
    settle();
    check_idle("f_done");

    // Abort without ack, then stray ack in IDLE
    instr_m_addr = 19'h00555; instr_m_access = 1'b1;
    step();
    check("a_state", 32'(state_dbg), 32'(S_GI));
    instr_m_access = 1'b0;
    settle();
    check("a_qacc", 32'(q_m_access), 32'd0);
    check("a_iack", 32'(instr_m_ack), 32'd0);
    step();
    check_idle("a_done");
    q_m_ack = 1'b1;
    settle();
    check("s_iack", 32'(instr_m_ack), 32'd0);
    check("s_dack", 32'(data_m_ack), 32'd0);
    step();
    check_idle("s_after");
    q_m_ack = 1'b0;

    // Reset mid-grant with ack high; last_was_data must return to ~DATA_FIRST
    data_m_addr = 19'h00666; data_m_access = 1'b1;
    step();
    check("r_state", 32'(state_dbg), 32'(S_GD));
    q_m_ack = 1'b1; reset = 1'b1;
    step();
    check_idle("r_after");
    reset = 1'b0; q_m_ack = 1'b0;
    instr_m_addr = 19'h00777; instr_m_access = 1'b1;
    data_m_addr = 19'h00888;
    settle();
    check("r_idle_qacc", 32'(q_m_access), 32'd0);
    step();
    check("r_fresh_state", 32'(state_dbg), 32'(S_GD));
    check("r_fresh_qaddr", 32'(q_m_addr), 32'h00888);
    instr_m_access = 1'b0; data_m_access = 1'b0;
    step();
    check_idle("r_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
